// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and constants for the multicycle RV32I control FSM.
package ctrl_pkg;

   // Controller states (4-bit encoding)
   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBeq      = 4'd9,
      StJal      = 4'd10,
      StLui      = 4'd11,
      StTrap     = 4'd12
   } state_e;

   // Opcodes
   localparam logic [6:0] OP_LW  = 7'd3;
   localparam logic [6:0] OP_SW  = 7'd35;
   localparam logic [6:0] OP_R   = 7'd51;
   localparam logic [6:0] OP_I   = 7'd19;
   localparam logic [6:0] OP_BEQ = 7'd99;
   localparam logic [6:0] OP_JAL = 7'd111;
   localparam logic [6:0] OP_LUI = 7'd55;

   // Result mux
   localparam logic [1:0] RES_ALU_OUT    = 2'b00;
   localparam logic [1:0] RES_MEM_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU_RESULT = 2'b10;

   // ALU operand A mux
   localparam logic [1:0] A_PC     = 2'b00;
   localparam logic [1:0] A_OLD_PC = 2'b01;
   localparam logic [1:0] A_RS1    = 2'b10;
   localparam logic [1:0] A_ZERO   = 2'b11;

   // ALU operand B mux
   localparam logic [1:0] B_RS2  = 2'b00;
   localparam logic [1:0] B_IMM  = 2'b01;
   localparam logic [1:0] B_FOUR = 2'b10;

   // ALU operation class handed to alu_deco
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // Immediate formats
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath signal bundle. master = controller, slave = datapath.
interface multicycle_ctrl_fsm_if #(
   parameter int unsigned CNT_W = 32
);
   logic [6:0]       op;
   logic             memReady;
   logic             pcUpdate;
   logic             branch;
   logic             regWrite;
   logic             memWrite;
   logic             irWrite;
   logic             adrSrc;
   logic [1:0]       resSrc;
   logic [1:0]       aluSrcA;
   logic [1:0]       aluSrcB;
   logic [1:0]       aluOp;
   logic [2:0]       immSrc;
   logic             illegalOp;
   logic [CNT_W-1:0] instret;

   modport master (
      input  op, memReady,
      output pcUpdate, branch, regWrite, memWrite, irWrite, adrSrc, resSrc,
             aluSrcA, aluSrcB, aluOp, immSrc, illegalOp, instret
   );

   modport slave (
      output op, memReady,
      input  pcUpdate, branch, regWrite, memWrite, irWrite, adrSrc, resSrc,
             aluSrcA, aluSrcB, aluOp, immSrc, illegalOp, instret
   );
endinterface

// File: rtl/multicycle_ctrl_fsm_imm_src_deco.sv
// Immediate-format decoder: purely combinational from the opcode.
module imm_src_deco
   import ctrl_pkg::*;
(
   input  logic [6:0] op_i,
   output logic [2:0] imm_src_o
);

   // Opcode -> immediate format; unknown opcodes fall back to I-type encoding
   always_comb begin
      imm_src_o = IMM_I;
      case (op_i)
         OP_LW, OP_I: imm_src_o = IMM_I;
         OP_SW:       imm_src_o = IMM_S;
         OP_BEQ:      imm_src_o = IMM_B;
         OP_JAL:      imm_src_o = IMM_J;
         OP_LUI:      imm_src_o = IMM_U;
         default:     imm_src_o = IMM_I;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared ALU and memory port, with memory-ready stalls, illegal-opcode trap and instret.
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter bit          USE_MEM_READY = 1'b1,
   parameter bit          SUPPORT_LUI   = 1'b1,
   parameter int unsigned CNT_W         = 32
) (
   input logic                  clk,
   input logic                  rst_n,
   multicycle_ctrl_fsm_if.master bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic       ready;
   logic       retire;
   logic       pc_upd, br, rw, mw, irw;
   logic       adr_src, ill;
   logic [1:0] res_src, src_a, src_b, alu_op;

   assign ready = USE_MEM_READY ? bus.memReady : 1'b1;

   imm_src_deco u_imm_src_deco (
      .op_i      (bus.op),
      .imm_src_o (bus.immSrc)
   );

   // State and retired-instruction counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   // Next state and Moore output table
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      pc_upd  = 1'b0;
      br      = 1'b0;
      rw      = 1'b0;
      mw      = 1'b0;
      irw     = 1'b0;
      ill     = 1'b0;
      adr_src = 1'b0;
      res_src = RES_ALU_OUT;
      src_a   = A_PC;
      src_b   = B_RS2;
      alu_op  = ALU_ADD;
      case (state_q)
         StFetch: begin
            res_src = RES_ALU_RESULT;
            src_b   = B_FOUR;
            irw     = ready;
            pc_upd  = ready;
            if (ready) state_d = StDecode;
         end
         StDecode: begin
            // Precompute the branch target while the opcode is decoded
            src_a = A_OLD_PC;
            src_b = B_IMM;
            case (bus.op)
               OP_LW, OP_SW: state_d = StMemAdr;
               OP_R:         state_d = StExecR;
               OP_I:         state_d = StExecI;
               OP_BEQ:       state_d = StBeq;
               OP_JAL:       state_d = StJal;
               OP_LUI:       state_d = SUPPORT_LUI ? StLui : StTrap;
               default:      state_d = StTrap;
            endcase
         end
         StMemAdr: begin
            src_a = A_RS1;
            src_b = B_IMM;
            case (bus.op)
               OP_LW:   state_d = StMemRead;
               OP_SW:   state_d = StMemWrite;
               default: state_d = StTrap;
            endcase
         end
         StMemRead: begin
            adr_src = 1'b1;
            if (ready) state_d = StMemWb;
         end
         StMemWb: begin
            res_src = RES_MEM_DATA;
            rw      = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
         end
         StMemWrite: begin
            // Write strobe stays up until memory accepts it
            adr_src = 1'b1;
            mw      = 1'b1;
            if (ready) begin
               retire  = 1'b1;
               state_d = StFetch;
            end
         end
         StExecR: begin
            src_a   = A_RS1;
            alu_op  = ALU_FUNCT;
            state_d = StAluWb;
         end
         StExecI: begin
            src_a   = A_RS1;
            src_b   = B_IMM;
            alu_op  = ALU_FUNCT;
            state_d = StAluWb;
         end
         StAluWb: begin
            rw      = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
         end
         StBeq: begin
            src_a   = A_RS1;
            alu_op  = ALU_SUB;
            br      = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
         end
         StJal: begin
            // PC <- target (aluOut from DECODE); aluResult = oldPC + 4 for rd
            src_a   = A_OLD_PC;
            src_b   = B_FOUR;
            pc_upd  = 1'b1;
            state_d = StAluWb;
         end
         StLui: begin
            src_a   = A_ZERO;
            src_b   = B_IMM;
            state_d = StAluWb;
         end
         StTrap: begin
            ill = 1'b1;
         end
         default: state_d = StTrap;
      endcase
      instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
   end

   // Strobes are gated by reset so nothing fires while rst_n is low
   assign bus.pcUpdate  = pc_upd & rst_n;
   assign bus.branch    = br & rst_n;
   assign bus.regWrite  = rw & rst_n;
   assign bus.memWrite  = mw & rst_n;
   assign bus.irWrite   = irw & rst_n;
   assign bus.adrSrc    = adr_src;
   assign bus.resSrc    = res_src;
   assign bus.aluSrcA   = src_a;
   assign bus.aluSrcB   = src_b;
   assign bus.aluOp     = alu_op;
   assign bus.illegalOp = ill;
   assign bus.instret   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: instruction-level reference model drives expected per-cycle outputs
// for two controller configurations (full features / no memReady, no LUI, 3-bit counter).
module tb_multicycle_ctrl_fsm;

   typedef struct packed {
      logic        pc, br, rw, mw, ir, adr;
      logic [1:0]  res, sa, sb, aop;
      logic [2:0]  imm;
      logic        ill;
      logic [31:0] cnt;
   } obs_t;

   localparam int PhF = 0, PhD = 1, PhMa = 2, PhMr = 3, PhMwb = 4, PhMw = 5, PhEr = 6;
   localparam int PhEi = 7, PhAwb = 8, PhBeq = 9, PhJal = 10, PhLui = 11, PhTrap = 12;
   localparam int PhRst = 13;

   logic       clk = 1'b0;
   logic       rst_drv, rdy_drv, sel, chk_en;
   logic [6:0] op_drv;
   logic       rst_a, rst_b;

   obs_t        exp_v, act_v;
   int unsigned model_cnt;
   int          n_tests, n_fail;
   int          cyc_idx, t_rw, t_mw, t_br, t_pc, mw_run, mw_max, last_rw, br_idx;

   always #5 clk = ~clk;

   assign rst_a = (sel == 1'b0) ? rst_drv : 1'b0;
   assign rst_b = (sel == 1'b1) ? rst_drv : 1'b0;

   multicycle_ctrl_fsm_if #(.CNT_W(32)) bus_a ();
   multicycle_ctrl_fsm_if #(.CNT_W(3))  bus_b ();

   assign bus_a.op       = op_drv;
   assign bus_a.memReady = rdy_drv;
   assign bus_b.op       = op_drv;
   assign bus_b.memReady = rdy_drv;

   multicycle_ctrl_fsm #(.USE_MEM_READY(1'b1), .SUPPORT_LUI(1'b1), .CNT_W(32)) dut_a (
      .clk   (clk),
      .rst_n (rst_a),
      .bus   (bus_a)
   );

   multicycle_ctrl_fsm #(.USE_MEM_READY(1'b0), .SUPPORT_LUI(1'b0), .CNT_W(3)) dut_b (
      .clk   (clk),
      .rst_n (rst_b),
      .bus   (bus_b)
   );

   function automatic logic [2:0] imm_of(input logic [6:0] o);
      case (o)
         7'd35:   return 3'b001;
         7'd99:   return 3'b010;
         7'd111:  return 3'b011;
         7'd55:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // Expected outputs for one step of an instruction, straight from the output table
   function automatic obs_t phase_vec(input int ph, input logic eff, input logic [6:0] o,
                                      input logic [31:0] cnt);
      obs_t v;
      v     = '0;
      v.imm = imm_of(o);
      v.cnt = cnt;
      case (ph)
         PhF:    begin v.res = 2'b10; v.sb = 2'b10; v.ir = eff; v.pc = eff; end
         PhRst:  begin v.res = 2'b10; v.sb = 2'b10; end
         PhD:    begin v.sa = 2'b01; v.sb = 2'b01; end
         PhMa:   begin v.sa = 2'b10; v.sb = 2'b01; end
         PhMr:   v.adr = 1'b1;
         PhMwb:  begin v.res = 2'b01; v.rw = 1'b1; end
         PhMw:   begin v.adr = 1'b1; v.mw = 1'b1; end
         PhEr:   begin v.sa = 2'b10; v.aop = 2'b10; end
         PhEi:   begin v.sa = 2'b10; v.sb = 2'b01; v.aop = 2'b10; end
         PhAwb:  v.rw = 1'b1;
         PhBeq:  begin v.sa = 2'b10; v.aop = 2'b01; v.br = 1'b1; end
         PhJal:  begin v.sa = 2'b01; v.sb = 2'b10; v.pc = 1'b1; end
         PhLui:  begin v.sa = 2'b11; v.sb = 2'b01; end
         PhTrap: v.ill = 1'b1;
         default: v = '0;
      endcase
      return v;
   endfunction

   function automatic obs_t sample();
      obs_t a;
      if (sel == 1'b0) begin
         a = {bus_a.pcUpdate, bus_a.branch, bus_a.regWrite, bus_a.memWrite, bus_a.irWrite,
              bus_a.adrSrc, bus_a.resSrc, bus_a.aluSrcA, bus_a.aluSrcB, bus_a.aluOp,
              bus_a.immSrc, bus_a.illegalOp, bus_a.instret};
      end else begin
         a = {bus_b.pcUpdate, bus_b.branch, bus_b.regWrite, bus_b.memWrite, bus_b.irWrite,
              bus_b.adrSrc, bus_b.resSrc, bus_b.aluSrcA, bus_b.aluSrcB, bus_b.aluOp,
              bus_b.immSrc, bus_b.illegalOp, {29'd0, bus_b.instret}};
      end
      return a;
   endfunction

   function automatic logic [31:0] cnt_exp();
      return (sel == 1'b1) ? (model_cnt & 32'd7) : model_cnt;
   endfunction

   // Per-cycle compare against the model, plus strobe tallies for the literal checks
   always @(negedge clk) begin
      #2;
      if (chk_en) begin
         act_v = sample();
         n_tests++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t dut=%0d op=%0d got=%h expected=%h",
                     $time, sel, op_drv, act_v, exp_v);
         end
         if (act_v.rw) begin t_rw++; last_rw = cyc_idx; end
         if (act_v.br) begin t_br++; br_idx = cyc_idx; end
         if (act_v.pc) t_pc++;
         if (act_v.mw) begin
            t_mw++;
            mw_run++;
            if (mw_run > mw_max) mw_max = mw_run;
         end else begin
            mw_run = 0;
         end
         cyc_idx++;
      end
   end

   task automatic chk(input string name, input longint act, input longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic clear_tally();
      cyc_idx = 0; t_rw = 0; t_mw = 0; t_br = 0; t_pc = 0;
      mw_run = 0; mw_max = 0; last_rw = -1; br_idx = -1;
   endtask

   task automatic step(input logic [6:0] o, input logic r, input logic rs, input obs_t e);
      @(negedge clk);
      op_drv  = o;
      rdy_drv = r;
      rst_drv = rs;
      exp_v   = e;
      chk_en  = 1'b1;
   endtask

   task automatic do_reset(input int n);
      model_cnt = 0;
      repeat (n) step(op_drv, 1'($urandom_range(0, 1)), 1'b0, phase_vec(PhRst, 1'b0, op_drv, 0));
   endtask

   // Run one instruction: build its phase list, then walk it cycle by cycle with stalls
   task automatic run_instr(input logic [6:0] o, input logic [15:0] pat, input bit use_pat,
                            input int abort_at, output int cycles, output bit trapped);
      int   seq[$];
      bit   legal, use_rdy, lui_ok;
      int   idx, waits, ph;
      logic r, eff;
      use_rdy = (sel == 1'b0);
      lui_ok  = (sel == 1'b0);
      trapped = 1'b0;
      clear_tally();
      seq   = {PhF, PhD};
      legal = 1'b1;
      case (o)
         7'd3:    begin seq.push_back(PhMa); seq.push_back(PhMr); seq.push_back(PhMwb); end
         7'd35:   begin seq.push_back(PhMa); seq.push_back(PhMw); end
         7'd51:   begin seq.push_back(PhEr); seq.push_back(PhAwb); end
         7'd19:   begin seq.push_back(PhEi); seq.push_back(PhAwb); end
         7'd99:   seq.push_back(PhBeq);
         7'd111:  begin seq.push_back(PhJal); seq.push_back(PhAwb); end
         7'd55:   if (lui_ok) begin seq.push_back(PhLui); seq.push_back(PhAwb); end
                  else legal = 1'b0;
         default: legal = 1'b0;
      endcase
      if (!legal) repeat (3) seq.push_back(PhTrap);
      idx = 0; cycles = 0; waits = 0;
      while (idx < seq.size()) begin
         if (cycles == abort_at) begin
            do_reset(1 + int'($urandom_range(0, 1)));
            cycles = -1;
            return;
         end
         ph = seq[idx];
         if (use_pat && cycles < 16) r = pat[cycles];
         else r = ($urandom_range(0, 2) != 0);
         if (waits >= 6) r = 1'b1;
         eff = use_rdy ? r : 1'b1;
         step(o, r, 1'b1, phase_vec(ph, eff, o, cnt_exp()));
         cycles++;
         if ((ph == PhF || ph == PhMr || ph == PhMw) && !eff) waits++;
         else begin idx++; waits = 0; end
      end
      if (legal) model_cnt++;
      else trapped = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic random_run(input int n);
      int cyc, k;
      bit tr;
      logic [6:0] o;
      for (int i = 0; i < n; i++) begin
         k = int'($urandom_range(0, 9));
         case (k)
            0: o = 7'd3;   1: o = 7'd35;  2: o = 7'd51;  3: o = 7'd19;  4: o = 7'd99;
            5: o = 7'd111; 6: o = 7'd55;  7: o = 7'h7F;  8: o = 7'($urandom_range(0, 127));
            default: o = 7'd51;
         endcase
         run_instr(o, 16'h0, 1'b0,
                   ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 3)) : -1, cyc, tr);
         if (tr) do_reset(1 + int'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      int cyc;
      bit tr;
      n_tests = 0; n_fail = 0; model_cnt = 0;
      sel = 1'b0; rst_drv = 1'b0; op_drv = 7'd51; rdy_drv = 1'b1; chk_en = 1'b0;
      exp_v = '0;
      clear_tally();

      // Configuration A: memReady honoured, LUI supported
      do_reset(3);
      #3;
      chk("rst_instret", bus_a.instret, 0);
      chk("rst_irwrite", bus_a.irWrite, 0);
      chk("rst_regwrite", bus_a.regWrite, 0);

      run_instr(7'd51, 16'hFFFF, 1'b1, -1, cyc, tr);
      chk("add_cycles", cyc, 4);
      chk("add_regwrite_cnt", t_rw, 1);
      chk("add_regwrite_cycle", last_rw, 3);
      chk("add_instret", bus_a.instret, 1);

      run_instr(7'd3, 16'hFFE7, 1'b1, -1, cyc, tr);
      chk("lw_stall_cycles", cyc, 7);
      chk("lw_regwrite_cnt", t_rw, 1);

      run_instr(7'd35, 16'hFFF7, 1'b1, -1, cyc, tr);
      chk("sw_stall_cycles", cyc, 5);
      chk("sw_memwrite_run", mw_max, 2);
      chk("sw_regwrite_cnt", t_rw, 0);

      run_instr(7'd99, 16'hFFFF, 1'b1, -1, cyc, tr);
      chk("beq_cycles", cyc, 3);
      chk("beq_branch_cnt", t_br, 1);
      chk("beq_branch_cycle", br_idx, 2);

      run_instr(7'd111, 16'hFFFF, 1'b1, -1, cyc, tr);
      chk("jal_pcupdate_cnt", t_pc, 2);
      chk("jal_regwrite_cnt", t_rw, 1);
      chk("jal_instret", bus_a.instret, 5);

      run_instr(7'd55, 16'hFFFF, 1'b1, -1, cyc, tr);
      chk("lui_cycles", cyc, 4);
      chk("lui_instret", bus_a.instret, 6);

      run_instr(7'h7F, 16'hFFFF, 1'b1, -1, cyc, tr);
      chk("trap_illegal", bus_a.illegalOp, 1);
      chk("trap_instret_kept", bus_a.instret, 6);
      do_reset(2);
      #3;
      chk("trap_cleared", bus_a.illegalOp, 0);

      random_run(200);

      // Configuration B: memReady ignored, LUI traps, 3-bit wrapping counter
      @(negedge clk);
      chk_en  = 1'b0;
      rst_drv = 1'b0;
      sel     = 1'b1;
      do_reset(2);

      run_instr(7'd55, 16'h0000, 1'b1, -1, cyc, tr);
      chk("nolui_trap", bus_b.illegalOp, 1);
      do_reset(1);

      run_instr(7'd35, 16'h0000, 1'b1, -1, cyc, tr);
      chk("b_sw_cycles", cyc, 4);
      chk("b_sw_memwrite_cnt", t_mw, 1);

      for (int i = 0; i < 8; i++) run_instr(7'd19, 16'h0000, 1'b1, -1, cyc, tr);
      chk("b_instret_wrap", bus_b.instret, 1);

      random_run(200);

      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard time limit so the run always terminates
   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
